// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants and types for the RAM read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int num_req_lp = 2;

    typedef logic req_id_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_arb_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_2
// Description : Two-input round-robin arbiter with registered last-winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_2
    import ram_arb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [num_req_lp-1:0] i_eligible,
    output logic [num_req_lp-1:0] o_grant,
    output req_id_t               o_winner,
    output req_id_t               o_last
);

    req_id_t r_last;
    req_id_t w_winner;

    always_comb begin
        w_winner = r_last;
        case (i_eligible)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last;
            default: w_winner = r_last;
        endcase
    end

    assign o_grant  = (i_eligible == '0) ? '0 : (w_winner ? 2'b10 : 2'b01);
    assign o_winner = w_winner;
    assign o_last   = r_last;

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last <= 1'b1;
        end else if (|i_eligible) begin
            r_last <= w_winner;
        end
    end

endmodule : rr_arb_2
`default_nettype wire

// File: rtl/ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_rd_arbiter
// Description : Shares a 1R1W RAM read port between two requesters with
//               per-requester one-entry response buffers; writes pass through.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 128
)
(
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [num_req_lp-1:0]                         req_valid_i,
    input  logic [num_req_lp-1:0][$clog2(depth_p)-1:0]    req_addr_i,
    output logic [num_req_lp-1:0]                         req_ready_o,
    output logic [num_req_lp-1:0]                         resp_valid_o,
    output logic [num_req_lp-1:0][width_p-1:0]            resp_data_o,
    input  logic [num_req_lp-1:0]                         resp_ready_i,
    input  logic                                          wr_valid_i,
    input  logic [$clog2(depth_p)-1:0]                    wr_addr_i,
    input  logic [width_p-1:0]                            wr_data_i,
    output logic                                          ram_wr_valid_o,
    output logic [$clog2(depth_p)-1:0]                    ram_wr_addr_o,
    output logic [width_p-1:0]                            ram_wr_data_o,
    output logic [$clog2(depth_p)-1:0]                    ram_rd_addr_o,
    input  logic [width_p-1:0]                            ram_rd_data_i
);

    logic [num_req_lp-1:0]              r_inflight;
    logic [num_req_lp-1:0]              r_slot_v;
    logic [num_req_lp-1:0][width_p-1:0] r_slot_d;

    logic [num_req_lp-1:0] w_eligible;
    logic [num_req_lp-1:0] w_grant;
    req_id_t               w_winner;
    req_id_t               w_last;

    assign ram_wr_valid_o = wr_valid_i;
    assign ram_wr_addr_o  = wr_addr_i;
    assign ram_wr_data_o  = wr_data_i;

    // A requester may be granted in the same cycle its buffered response drains.
    assign w_eligible = req_valid_i & ~r_inflight & (~r_slot_v | resp_ready_i);

    rr_arb_2 u_rr_arb_2 (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .i_eligible (w_eligible),
        .o_grant    (w_grant),
        .o_winner   (w_winner),
        .o_last     (w_last)
    );

    assign req_ready_o   = w_grant;
    assign ram_rd_addr_o = (|w_grant) ? req_addr_i[w_winner] : req_addr_i[w_last];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_inflight <= '0;
            r_slot_v   <= '0;
            r_slot_d   <= '0;
        end else begin
            r_inflight <= w_grant;
            for (int i = 0; i < num_req_lp; i++) begin
                if (r_inflight[i]) begin
                    r_slot_d[i] <= ram_rd_data_i;
                    r_slot_v[i] <= 1'b1;
                end else if (r_slot_v[i] && resp_ready_i[i]) begin
                    r_slot_v[i] <= 1'b0;
                end
            end
        end
    end

    assign resp_valid_o = r_slot_v;
    assign resp_data_o  = r_slot_d;

endmodule : ram_rd_arbiter
`default_nettype wire

// File: tb/tb_ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rd_arbiter
// Description : Self-checking bench for ram_rd_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rd_arbiter;

    localparam int W  = 8;
    localparam int D  = 128;
    localparam int AW = 7;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [1:0]          req_valid;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0]          req_ready;
    logic [1:0]          resp_valid;
    logic [1:0][W-1:0]   resp_data;
    logic [1:0]          resp_ready;
    logic                wr_valid;
    logic [AW-1:0]       wr_addr;
    logic [W-1:0]        wr_data;
    logic                ram_wr_valid;
    logic [AW-1:0]       ram_wr_addr;
    logic [W-1:0]        ram_wr_data;
    logic [AW-1:0]       ram_rd_addr;
    logic [W-1:0]        ram_rd_data;

    logic [W-1:0]        mem [0:D-1];

    int n_assert = 0;
    int n_fail   = 0;
    int npop0    = 0;
    int npop1    = 0;
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic [1:0]   s_ready;
    logic [1:0]   s_rv;
    logic [W-1:0] s_d0;
    logic [W-1:0] s_d1;

    always #5 clk = ~clk;

    ram_rd_arbiter #(.width_p(W), .depth_p(D)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_ready_o    (req_ready),
        .resp_valid_o   (resp_valid),
        .resp_data_o    (resp_data),
        .resp_ready_i   (resp_ready),
        .wr_valid_i     (wr_valid),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .ram_wr_valid_o (ram_wr_valid),
        .ram_wr_addr_o  (ram_wr_addr),
        .ram_wr_data_o  (ram_wr_data),
        .ram_rd_addr_o  (ram_rd_addr),
        .ram_rd_data_i  (ram_rd_data)
    );

    // Synchronous-read RAM; a same-cycle write is seen by the next read only.
    initial begin
        for (int i = 0; i < D; i++) mem[i] <= W'(i + 8'h10);
        mem[5]      <= 8'hA5;
        mem[9]      <= 8'h00;
        ram_rd_data <= '0;
        forever begin
            @(posedge clk);
            if (ram_wr_valid) mem[ram_wr_addr] <= ram_wr_data;
            ram_rd_data <= mem[ram_rd_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: sample at negedge, update scoreboard, return after posedge.
    task automatic tick();
        @(negedge clk);
        chk("wr_pass", {15'd0, ram_wr_valid, ram_wr_addr, ram_wr_data},
                       {15'd0, wr_valid, wr_addr, wr_data});
        for (int i = 0; i < 2; i++) begin
            if (req_ready[i]) begin
                chk("rd_addr", 32'(ram_rd_addr), 32'(req_addr[i]));
                if (i == 0) q0.push_back(mem[req_addr[0]]);
                else        q1.push_back(mem[req_addr[1]]);
            end
        end
        if (resp_valid[0] && resp_ready[0]) begin
            npop0++;
            if (q0.size() == 0) chk("resp0_spurious", 32'(resp_valid[0]), 32'd0);
            else                chk("resp0_data", 32'(resp_data[0]), 32'(q0.pop_front()));
        end
        if (resp_valid[1] && resp_ready[1]) begin
            npop1++;
            if (q1.size() == 0) chk("resp1_spurious", 32'(resp_valid[1]), 32'd0);
            else                chk("resp1_data", 32'(resp_data[1]), 32'(q1.pop_front()));
        end
        s_ready = req_ready;
        s_rv    = resp_valid;
        s_d0    = resp_data[0];
        s_d1    = resp_data[1];
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        req_valid  = '0;
        wr_valid   = 1'b0;
        resp_ready = 2'b11;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit            rst;
        logic [1:0]    v;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    exp_ready;
        logic [1:0]    exp_rv;
    } vec_t;

    vec_t vecs [10];

    initial begin
        reset_n    = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        resp_ready = 2'b11;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        // Single read of mem[5], then a tie on addresses 1/2 right after reset.
        vecs[0] = '{1'b1, 2'b00, 7'd0, 7'd0, 2'b00, 2'b00};
        vecs[1] = '{1'b0, 2'b01, 7'd5, 7'd0, 2'b01, 2'b00};
        vecs[2] = '{1'b0, 2'b00, 7'd5, 7'd0, 2'b00, 2'b00};
        vecs[3] = '{1'b0, 2'b00, 7'd5, 7'd0, 2'b00, 2'b01};
        vecs[4] = '{1'b0, 2'b00, 7'd5, 7'd0, 2'b00, 2'b00};
        vecs[5] = '{1'b1, 2'b11, 7'd1, 7'd2, 2'b01, 2'b00};
        vecs[6] = '{1'b0, 2'b11, 7'd1, 7'd2, 2'b10, 2'b00};
        vecs[7] = '{1'b0, 2'b00, 7'd1, 7'd2, 2'b00, 2'b01};
        vecs[8] = '{1'b0, 2'b00, 7'd1, 7'd2, 2'b00, 2'b10};
        vecs[9] = '{1'b0, 2'b00, 7'd1, 7'd2, 2'b00, 2'b00};

        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            if (vecs[k].rst) apply_reset();
            req_valid   = vecs[k].v;
            req_addr[0] = vecs[k].a0;
            req_addr[1] = vecs[k].a1;
            tick();
            chk($sformatf("vec%0d_ready", k), 32'(s_ready), 32'(vecs[k].exp_ready));
            chk($sformatf("vec%0d_rvalid", k), 32'(s_rv), 32'(vecs[k].exp_rv));
            if (k == 3) chk("single_data", 32'(s_d0), 32'h A5);
            if (k == 7) chk("tie_data0", 32'(s_d0), 32'h11);
            if (k == 8) chk("tie_data1", 32'(s_d1), 32'h12);
        end

        // Sustained contention: grants alternate starting with requester 0.
        npop0 = 0;
        npop1 = 0;
        req_valid = 2'b11;
        for (int k = 0; k < 20; k++) begin
            req_addr[0] = AW'($urandom_range(0, D - 1));
            req_addr[1] = AW'($urandom_range(0, D - 1));
            tick();
            chk("contend_ready", 32'(s_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        req_valid = 2'b00;
        repeat (3) tick();
        chk("contend_cnt0", 32'(npop0), 32'd10);
        chk("contend_cnt1", 32'(npop1), 32'd10);

        // Backpressure on requester 1 while requester 0 keeps being served.
        req_addr[0] = 7'd8;
        req_addr[1] = 7'd7;
        req_valid = 2'b10;
        tick();
        chk("bp_c0_ready", 32'(s_ready), 32'd2);
        req_valid = 2'b01;
        tick();
        chk("bp_c1_ready", 32'(s_ready), 32'd1);
        req_valid  = 2'b11;
        resp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_ready", 32'(s_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("bp_rvalid1", 32'(s_rv[1]), 32'd1);
            chk("bp_data1", 32'(s_d1), 32'h17);
        end
        resp_ready = 2'b11;
        tick();
        chk("bp_release_ready", 32'(s_ready), 32'd2);
        req_valid = 2'b00;
        repeat (3) tick();

        // Same-cycle write and read to address 9 returns the old data.
        req_valid   = 2'b01;
        req_addr[0] = 7'd9;
        wr_valid    = 1'b1;
        wr_addr     = 7'd9;
        wr_data     = 8'h3C;
        tick();
        chk("rdw_ready", 32'(s_ready), 32'd1);
        wr_valid  = 1'b0;
        req_valid = 2'b00;
        tick();
        tick();
        chk("rdw_rvalid", 32'(s_rv), 32'd1);
        chk("rdw_old", 32'(s_d0), 32'h00);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        chk("rdw_new", 32'(s_d0), 32'h3C);
        repeat (2) tick();

        // Asynchronous reset with a read in flight and a response held.
        resp_ready  = 2'b01;
        req_addr[0] = 7'd4;
        req_addr[1] = 7'd3;
        req_valid   = 2'b10;
        tick();
        chk("ar_c0_ready", 32'(s_ready), 32'd2);
        req_valid = 2'b01;
        tick();
        chk("ar_c1_ready", 32'(s_ready), 32'd1);
        req_valid = 2'b00;
        #2;
        chk("ar_pre_rvalid", 32'(resp_valid), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("ar_async_rvalid", 32'(resp_valid), 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        resp_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_post_rvalid", 32'(s_rv), 32'd0);
        end
        req_valid   = 2'b11;
        req_addr[0] = 7'd1;
        req_addr[1] = 7'd2;
        tick();
        chk("ar_tie_ready", 32'(s_ready), 32'd1);
        req_valid = 2'b00;
        repeat (4) tick();

        chk("sb_empty0", 32'(q0.size()), 32'd0);
        chk("sb_empty1", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ram_rd_arbiter
`default_nettype wire
